// File: rtl/vinsn_decoder_pkg.sv
// Shared vector-decode types: instruction field encodings, vtype layout, micro-op payload and VLMAX helper.
package vinsn_decoder_pkg;

    localparam logic [6:0] OpcodeVec = 7'b1010111;

    // Instruction field positions
    localparam int unsigned FUNC6_MSB   = 31;
    localparam int unsigned FUNC6_LSB   = 26;
    localparam int unsigned VM_BIT      = 25;
    localparam int unsigned VS2_MSB     = 24;
    localparam int unsigned VS2_LSB     = 20;
    localparam int unsigned VS1_MSB     = 19;
    localparam int unsigned VS1_LSB     = 15;
    localparam int unsigned FUNC3_MSB   = 14;
    localparam int unsigned FUNC3_LSB   = 12;
    localparam int unsigned VD_MSB      = 11;
    localparam int unsigned VD_LSB      = 7;
    localparam int unsigned OPCODE_MSB  = 6;

    // OPCFG field positions
    localparam int unsigned CFG_SEL_BIT = 31;
    localparam int unsigned VTYPEI_MSB  = 30;
    localparam int unsigned VTYPEI_LSB  = 20;
    localparam int unsigned VTYPEI_W    = VTYPEI_MSB - VTYPEI_LSB + 1;

    typedef enum logic [2:0] {
        OPIVV = 3'b000,
        OPFVV = 3'b001,
        OPMVV = 3'b010,
        OPIVI = 3'b011,
        OPIVX = 3'b100,
        OPFVF = 3'b101,
        OPMVX = 3'b110,
        OPCFG = 3'b111
    } opcodev_func3_e;

    typedef enum logic [5:0] {
        OPVADD   = 6'b000000,
        OPVSUB   = 6'b000010,
        OPVMERGE = 6'b010111,
        OPVSLL   = 6'b100101,
        OPVSRL   = 6'b101000,
        OPVSRA   = 6'b101001
    } opcodev_func6_e;

    typedef enum logic [1:0] {
        EW8  = 2'b00,
        EW16 = 2'b01,
        EW32 = 2'b10,
        EW64 = 2'b11
    } vew_e;

    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_1_8  = 3'b101,
        LMUL_1_4  = 3'b110,
        LMUL_1_2  = 3'b111
    } vlmul_e;

    typedef struct packed {
        logic   vill;
        logic   vma;
        logic   vta;
        vew_e   vsew;
        vlmul_e vlmul;
    } vtype_t;

    localparam vtype_t VTYPE_RST = '{vill: 1'b1, vma: 1'b0, vta: 1'b0, vsew: EW8, vlmul: LMUL_1};

    // Width-independent micro-op fields; scalar and vl are carried alongside at their parameterised widths
    typedef struct packed {
        opcodev_func6_e func6;
        logic [4:0]     vd;
        logic [4:0]     vs1;
        logic [4:0]     vs2;
        logic           vm;
        logic           use_scalar;
        vew_e           vsew;
    } vinsn_t;

    // Elements per register group; fractional LMUL may legitimately round down to zero
    function automatic int unsigned vlmax_f(input int unsigned vlen, input vew_e sew, input vlmul_e lmul);
        int unsigned base;
        base = vlen >> (32'd3 + 32'(sew));
        case (lmul)
            LMUL_1:   return base;
            LMUL_2:   return base << 1;
            LMUL_4:   return base << 2;
            LMUL_8:   return base << 3;
            LMUL_1_2: return base >> 1;
            LMUL_1_4: return base >> 2;
            LMUL_1_8: return base >> 3;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/vinsn_decoder_vsetvl_calc.sv
// Combinational vsetvli evaluation: legalises vtypei and derives the new vl from AVL, VLMAX and old vl.
module vinsn_decoder_vsetvl_calc
    import vinsn_decoder_pkg::*;
#(
    parameter int unsigned VLEN = 256,
    parameter int unsigned XLEN = 32
) (
    input  logic [VTYPEI_W-1:0] vtypei,
    input  logic [XLEN-1:0]     avl,
    input  logic                rs1_zero,
    input  logic                rd_zero,
    input  logic [XLEN-1:0]     old_vl,
    output vtype_t              new_vtype,
    output logic [XLEN-1:0]     new_vl
);

    logic [2:0]      sew_raw;
    vlmul_e          lmul;
    logic            vill;
    logic [XLEN-1:0] vlmax;

    assign sew_raw = vtypei[5:3];
    assign lmul    = vlmul_e'(vtypei[2:0]);
    // SEW above 64 has no vew_e encoding, so it is treated as unsupported alongside reserved fields
    assign vill    = (lmul == LMUL_RSVD) || (|vtypei[10:8]) || sew_raw[2];
    assign vlmax   = XLEN'(vlmax_f(VLEN, vew_e'(sew_raw[1:0]), lmul));

    always_comb begin
        new_vtype = VTYPE_RST;
        new_vl    = '0;
        if (!vill) begin
            new_vtype = '{vill: 1'b0, vma: vtypei[7], vta: vtypei[6],
                          vsew: vew_e'(sew_raw[1:0]), vlmul: lmul};
            if (!rs1_zero) begin
                new_vl = (avl < vlmax) ? avl : vlmax;
            end else if (!rd_zero) begin
                new_vl = vlmax;
            end else begin
                new_vl = (old_vl < vlmax) ? old_vl : vlmax;
            end
        end
    end

endmodule

// File: rtl/vinsn_decoder.sv
// Vector front-end decode stage: executes vsetvli in place and registers OPIV* arithmetic micro-ops.
// Optional: RVV_VL_ZERO_SQUASH_EN drops arithmetic silently while vl is zero.
module vinsn_decoder
    import vinsn_decoder_pkg::*;
#(
    parameter  int unsigned VLEN = 256,
    parameter  int unsigned XLEN = 32,
    localparam int unsigned VL_W = $clog2(VLEN / 8) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            insn_valid_i,
    output logic            insn_ready_o,
    input  logic [31:0]     insn_i,
    input  logic [XLEN-1:0] rs1_i,
    output logic            op_valid_o,
    input  logic            op_ready_i,
    output logic [5:0]      op_func6_o,
    output logic [4:0]      op_vd_o,
    output logic [4:0]      op_vs1_o,
    output logic [4:0]      op_vs2_o,
    output logic            op_vm_o,
    output logic            op_use_scalar_o,
    output logic [XLEN-1:0] op_scalar_o,
    output logic [1:0]      op_vsew_o,
    output logic [VL_W-1:0] op_vl_o,
    output logic            cfg_valid_o,
    output logic [XLEN-1:0] cfg_vl_o,
    output logic            illegal_o,
    output logic [7:0]      vtype_o
);

    logic [6:0]      opcode;
    opcodev_func3_e  func3;
    opcodev_func6_e  func6;
    logic            vm;
    logic [4:0]      vs2, vs1, vd;

    logic            accept;
    logic            is_vec, is_cfg, is_arith;
    logic            func6_ok, is_shift, merge_bad, arith_ok;
    logic            squash, issue, illegal_c;
    vinsn_t          op_d, op_q;
    logic [XLEN-1:0] scalar_d, scalar_q;
    logic [VL_W-1:0] op_vl_q;
    logic            op_valid_q, cfg_valid_q, illegal_q;
    logic [XLEN-1:0] cfg_vl_q;
    vtype_t          vtype_q, calc_vtype;
    logic [XLEN-1:0] vl_q, calc_vl;

    assign opcode = insn_i[OPCODE_MSB:0];
    assign func3  = opcodev_func3_e'(insn_i[FUNC3_MSB:FUNC3_LSB]);
    assign func6  = opcodev_func6_e'(insn_i[FUNC6_MSB:FUNC6_LSB]);
    assign vm     = insn_i[VM_BIT];
    assign vs2    = insn_i[VS2_MSB:VS2_LSB];
    assign vs1    = insn_i[VS1_MSB:VS1_LSB];
    assign vd     = insn_i[VD_MSB:VD_LSB];

    // Single pipeline register: accept whenever the slot is empty or draining this cycle
    assign insn_ready_o = !op_valid_q || op_ready_i;
    assign accept       = insn_valid_i && insn_ready_o;

    vinsn_decoder_vsetvl_calc #(
        .VLEN (VLEN),
        .XLEN (XLEN)
    ) u_vsetvl_calc (
        .vtypei    (insn_i[VTYPEI_MSB:VTYPEI_LSB]),
        .avl       (rs1_i),
        .rs1_zero  (vs1 == 5'd0),
        .rd_zero   (vd == 5'd0),
        .old_vl    (vl_q),
        .new_vtype (calc_vtype),
        .new_vl    (calc_vl)
    );

`ifdef RVV_VL_ZERO_SQUASH_EN
    assign squash = (vl_q == '0);
`else
    assign squash = 1'b0;
`endif

    // Instruction classification and legality
    always_comb begin
        is_vec    = (opcode == OpcodeVec);
        is_cfg    = is_vec && (func3 == OPCFG) && !insn_i[CFG_SEL_BIT];
        is_arith  = is_vec && ((func3 == OPIVV) || (func3 == OPIVX) || (func3 == OPIVI));
        func6_ok  = 1'b0;
        is_shift  = 1'b0;
        case (func6)
            OPVADD, OPVSUB, OPVMERGE: func6_ok = 1'b1;
            OPVSLL, OPVSRL, OPVSRA: begin
                func6_ok = 1'b1;
                is_shift = 1'b1;
            end
            default: func6_ok = 1'b0;
        endcase
        merge_bad = (func6 == OPVMERGE) &&
                    ((vm && (vs2 != 5'd0)) || ((func3 == OPIVV) && !vm && (vd == 5'd0)));
        arith_ok  = is_arith && func6_ok && !merge_bad && !vtype_q.vill;
        issue     = arith_ok && !squash;
        illegal_c = !is_cfg && !arith_ok;
    end

    // Micro-op payload, including the scalar operand selection
    always_comb begin
        op_d = '{func6: func6, vd: vd, vs1: vs1, vs2: vs2, vm: vm,
                 use_scalar: (func3 != OPIVV), vsew: vtype_q.vsew};
        scalar_d = '0;
        case (func3)
            OPIVX:   scalar_d = rs1_i;
            OPIVI:   scalar_d = is_shift ? XLEN'(vs1) : XLEN'($signed(vs1));
            default: scalar_d = '0;
        endcase
    end

    // Micro-op register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_valid_q <= 1'b0;
            op_q       <= '0;
            scalar_q   <= '0;
            op_vl_q    <= '0;
        end else if (accept && issue) begin
            op_valid_q <= 1'b1;
            op_q       <= op_d;
            scalar_q   <= scalar_d;
            op_vl_q    <= VL_W'(vl_q);
        end else if (op_ready_i) begin
            op_valid_q <= 1'b0;
        end
    end

    // Architectural vtype/vl and retirement pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vtype_q     <= VTYPE_RST;
            vl_q        <= '0;
            cfg_valid_q <= 1'b0;
            cfg_vl_q    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            cfg_valid_q <= accept && is_cfg;
            illegal_q   <= accept && illegal_c;
            if (accept && is_cfg) begin
                vtype_q  <= calc_vtype;
                vl_q     <= calc_vl;
                cfg_vl_q <= calc_vl;
            end
        end
    end

    assign op_valid_o      = op_valid_q;
    assign op_func6_o      = op_q.func6;
    assign op_vd_o         = op_q.vd;
    assign op_vs1_o        = op_q.vs1;
    assign op_vs2_o        = op_q.vs2;
    assign op_vm_o         = op_q.vm;
    assign op_use_scalar_o = op_q.use_scalar;
    assign op_scalar_o     = scalar_q;
    assign op_vsew_o       = op_q.vsew;
    assign op_vl_o         = op_vl_q;
    assign cfg_valid_o     = cfg_valid_q;
    assign cfg_vl_o        = cfg_vl_q;
    assign illegal_o       = illegal_q;
    assign vtype_o         = vtype_q;

endmodule

// File: tb/tb_vinsn_decoder.sv
// Directed self-checking bench for vinsn_decoder (VLEN=256, XLEN=32).
module tb_vinsn_decoder;

    logic        clk;
    logic        rst_n;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic        op_valid;
    logic        op_ready;
    logic [5:0]  op_func6;
    logic [4:0]  op_vd, op_vs1, op_vs2;
    logic        op_vm;
    logic        op_use_scalar;
    logic [31:0] op_scalar;
    logic [1:0]  op_vsew;
    logic [5:0]  op_vl;
    logic        cfg_valid;
    logic [31:0] cfg_vl;
    logic        illegal;
    logic [7:0]  vtype;

    int tests = 0;
    int fails = 0;

    vinsn_decoder #(.VLEN(256), .XLEN(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .insn_valid_i    (insn_valid),
        .insn_ready_o    (insn_ready),
        .insn_i          (insn),
        .rs1_i           (rs1),
        .op_valid_o      (op_valid),
        .op_ready_i      (op_ready),
        .op_func6_o      (op_func6),
        .op_vd_o         (op_vd),
        .op_vs1_o        (op_vs1),
        .op_vs2_o        (op_vs2),
        .op_vm_o         (op_vm),
        .op_use_scalar_o (op_use_scalar),
        .op_scalar_o     (op_scalar),
        .op_vsew_o       (op_vsew),
        .op_vl_o         (op_vl),
        .cfg_valid_o     (cfg_valid),
        .cfg_vl_o        (cfg_vl),
        .illegal_o       (illegal),
        .vtype_o         (vtype)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] F3_IVV = 3'b000, F3_MVV = 3'b010, F3_IVI = 3'b011, F3_IVX = 3'b100;
    localparam logic [5:0] F6_ADD = 6'h00, F6_SUB = 6'h02, F6_MRG = 6'h17, F6_SLL = 6'h25, F6_SRA = 6'h29;

    function automatic logic [31:0] enc_op(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                           input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd);
        return {f6, vm, vs2, vs1, f3, vd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vset(input logic [2:0] sew, input logic [2:0] lmul,
                                             input logic [4:0] rs1f, input logic [4:0] rd);
        return {1'b0, 5'b0, sew, lmul, rs1f, 3'b111, rd, 7'h57};
    endfunction

    // Present one instruction for a single edge, leaving time at edge+1
    task automatic send(input logic [31:0] w, input logic [31:0] r);
        insn_valid = 1'b1;
        insn       = w;
        rs1        = r;
        @(posedge clk); #1;
        insn_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; insn_valid = 1'b0; insn = '0; rs1 = '0; op_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (op_valid !== 1'b0) begin fails++; $display("FAIL reset_op_valid: got %0b want 0", op_valid); end
        tests++; if ({cfg_valid, illegal} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b want 00", {cfg_valid, illegal}); end
        tests++; if (vtype !== 8'h80) begin fails++; $display("FAIL reset_vtype: got %h want 80", vtype); end
        tests++; if ({op_scalar, op_vl, op_vd, op_func6} !== '0) begin fails++; $display("FAIL reset_op_data: got %h want 0", {op_scalar, op_vl, op_vd, op_func6}); end
        tests++; if (insn_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", insn_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vill_illegal();
        send(enc_op(F6_ADD, 1'b1, 5'd8, 5'd12, F3_IVV, 5'd4), 32'h0);
        tests++; if ({illegal, op_valid} !== 2'b10) begin fails++; $display("FAIL vill_arith: illegal/op_valid got %b want 10", {illegal, op_valid}); end
        tests++; if (vtype[7] !== 1'b1) begin fails++; $display("FAIL vill_still_set: got %0b want 1", vtype[7]); end
        @(posedge clk); #1;
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL illegal_pulse_width: got %0b want 0", illegal); end
    endtask

    task automatic test_vsetvli();
        send(enc_vset(3'b010, 3'b001, 5'd1, 5'd5), 32'd20);
        tests++; if ({cfg_valid, cfg_vl} !== {1'b1, 32'd16}) begin fails++; $display("FAIL vset_e32m2: cfg_valid/vl got %0b/%0d want 1/16", cfg_valid, cfg_vl); end
        tests++; if (vtype !== 8'h11) begin fails++; $display("FAIL vset_e32m2_vtype: got %h want 11", vtype); end
        send(enc_op(F6_ADD, 1'b1, 5'd8, 5'd12, F3_IVV, 5'd4), 32'h0);
        tests++; if ({op_valid, op_vl, op_vsew} !== {1'b1, 6'd16, 2'd2}) begin fails++; $display("FAIL vadd_vv_cfg: valid/vl/sew got %0b/%0d/%0d want 1/16/2", op_valid, op_vl, op_vsew); end
        tests++; if ({op_func6, op_vd, op_vs2, op_vs1, op_vm, op_use_scalar, op_scalar} !== {F6_ADD, 5'd4, 5'd8, 5'd12, 1'b1, 1'b0, 32'd0}) begin
            fails++; $display("FAIL vadd_vv_fields: got f6=%h vd=%0d vs2=%0d vs1=%0d vm=%0b us=%0b sc=%h", op_func6, op_vd, op_vs2, op_vs1, op_vm, op_use_scalar, op_scalar);
        end
        tests++; if (cfg_valid !== 1'b0) begin fails++; $display("FAIL cfg_pulse_width: got %0b want 0", cfg_valid); end
        // rs1=x0, rd=x0 keeps old vl clipped to the new VLMAX (e32 m1 -> 8)
        send(enc_vset(3'b010, 3'b000, 5'd0, 5'd0), 32'd99);
        tests++; if (cfg_vl !== 32'd8) begin fails++; $display("FAIL vset_keep_vl: got %0d want 8", cfg_vl); end
        send(enc_vset(3'b000, 3'b101, 5'd0, 5'd3), 32'd99);
        tests++; if ({cfg_valid, cfg_vl, vtype} !== {1'b1, 32'd4, 8'h05}) begin fails++; $display("FAIL vset_e8mf8: valid/vl/vtype got %0b/%0d/%h want 1/4/05", cfg_valid, cfg_vl, vtype); end
        send(enc_vset(3'b000, 3'b100, 5'd1, 5'd3), 32'd10);
        tests++; if ({cfg_valid, cfg_vl, vtype} !== {1'b1, 32'd0, 8'h80}) begin fails++; $display("FAIL vset_rsvd_lmul: valid/vl/vtype got %0b/%0d/%h want 1/0/80", cfg_valid, cfg_vl, vtype); end
    endtask

    task automatic test_scalar_operand();
        send(enc_vset(3'b010, 3'b000, 5'd1, 5'd1), 32'd5);
        tests++; if (cfg_vl !== 32'd5) begin fails++; $display("FAIL vset_avl5: got %0d want 5", cfg_vl); end
        send(enc_op(F6_ADD, 1'b1, 5'd3, 5'b11101, F3_IVI, 5'd2), 32'h0);
        tests++; if ({op_valid, op_use_scalar, op_scalar} !== {1'b1, 1'b1, 32'hFFFF_FFFD}) begin fails++; $display("FAIL vadd_vi_simm: valid/us/scalar got %0b/%0b/%h want 1/1/fffffffd", op_valid, op_use_scalar, op_scalar); end
        send(enc_op(F6_SLL, 1'b1, 5'd3, 5'h1D, F3_IVI, 5'd2), 32'h0);
        tests++; if ({op_func6, op_scalar} !== {F6_SLL, 32'h1D}) begin fails++; $display("FAIL vsll_vi_uimm: f6/scalar got %h/%h want 25/1d", op_func6, op_scalar); end
        send(enc_op(F6_SRA, 1'b0, 5'd7, 5'h1F, F3_IVI, 5'd9), 32'h0);
        tests++; if ({op_scalar, op_vm} !== {32'h1F, 1'b0}) begin fails++; $display("FAIL vsra_vi_uimm: scalar/vm got %h/%0b want 1f/0", op_scalar, op_vm); end
        send(enc_op(F6_SUB, 1'b1, 5'd6, 5'd11, F3_IVX, 5'd1), 32'hDEAD_BEEF);
        tests++; if ({op_use_scalar, op_scalar, op_vl} !== {1'b1, 32'hDEAD_BEEF, 6'd5}) begin fails++; $display("FAIL vsub_vx: us/scalar/vl got %0b/%h/%0d want 1/deadbeef/5", op_use_scalar, op_scalar, op_vl); end
    endtask

    task automatic test_illegal();
        logic [31:0] cfg_hi;
        send(32'h0000_0013, 32'h0);
        tests++; if ({illegal, op_valid} !== 2'b10) begin fails++; $display("FAIL bad_opcode: illegal/op_valid got %b want 10", {illegal, op_valid}); end
        send(enc_op(F6_ADD, 1'b1, 5'd1, 5'd2, F3_MVV, 5'd3), 32'h0);
        tests++; if ({illegal, op_valid} !== 2'b10) begin fails++; $display("FAIL opmvv: illegal/op_valid got %b want 10", {illegal, op_valid}); end
        send(enc_op(6'h01, 1'b1, 5'd1, 5'd2, F3_IVV, 5'd3), 32'h0);
        tests++; if ({illegal, op_valid} !== 2'b10) begin fails++; $display("FAIL bad_func6: illegal/op_valid got %b want 10", {illegal, op_valid}); end
        cfg_hi = enc_vset(3'b000, 3'b000, 5'd1, 5'd1) | 32'h8000_0000;
        send(cfg_hi, 32'd3);
        tests++; if ({illegal, cfg_valid, vtype} !== {2'b10, 8'h10}) begin fails++; $display("FAIL opcfg_bit31: illegal/cfg/vtype got %0b/%0b/%h want 1/0/10", illegal, cfg_valid, vtype); end
    endtask

    task automatic test_merge();
        send(enc_op(F6_MRG, 1'b1, 5'd3, 5'd4, F3_IVX, 5'd2), 32'h55);
        tests++; if ({illegal, op_valid} !== 2'b10) begin fails++; $display("FAIL vmv_vs2_nonzero: illegal/op_valid got %b want 10", {illegal, op_valid}); end
        send(enc_op(F6_MRG, 1'b1, 5'd0, 5'd4, F3_IVX, 5'd2), 32'h55);
        tests++; if ({illegal, op_valid, op_func6, op_scalar} !== {2'b01, F6_MRG, 32'h55}) begin fails++; $display("FAIL vmv_vx_ok: ill/valid/f6/scalar got %0b/%0b/%h/%h", illegal, op_valid, op_func6, op_scalar); end
        send(enc_op(F6_MRG, 1'b0, 5'd5, 5'd4, F3_IVV, 5'd0), 32'h0);
        tests++; if ({illegal, op_valid} !== 2'b10) begin fails++; $display("FAIL vmerge_vvm_v0: illegal/op_valid got %b want 10", {illegal, op_valid}); end
    endtask

    task automatic test_backpressure();
        op_ready = 1'b0;
        send(enc_op(F6_ADD, 1'b1, 5'd8, 5'd12, F3_IVV, 5'd4), 32'h0);
        insn_valid = 1'b1;
        insn = enc_op(F6_SUB, 1'b1, 5'd1, 5'd2, F3_IVV, 5'd6);
        for (int i = 0; i < 3; i++) begin
            tests++; if ({insn_ready, op_valid, op_vd, op_func6} !== {2'b01, 5'd4, F6_ADD}) begin
                fails++; $display("FAIL stall_cycle%0d: ready/valid/vd/f6 got %0b/%0b/%0d/%h want 0/1/4/00", i, insn_ready, op_valid, op_vd, op_func6);
            end
            @(posedge clk); #1;
        end
        op_ready = 1'b1;
        #1;
        tests++; if (insn_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %0b want 1", insn_ready); end
        @(posedge clk); #1;
        insn_valid = 1'b0;
        tests++; if ({op_valid, op_vd, op_func6} !== {1'b1, 5'd6, F6_SUB}) begin fails++; $display("FAIL second_issue: valid/vd/f6 got %0b/%0d/%h want 1/6/02", op_valid, op_vd, op_func6); end
        @(posedge clk); #1;
        tests++; if (op_valid !== 1'b0) begin fails++; $display("FAIL drain: op_valid got %0b want 0", op_valid); end
    endtask

    task automatic test_back_to_back();
        insn_valid = 1'b1;
        insn = enc_vset(3'b001, 3'b000, 5'd1, 5'd1);
        rs1 = 32'd100;
        @(posedge clk); #1;
        tests++; if ({cfg_valid, cfg_vl} !== {1'b1, 32'd16}) begin fails++; $display("FAIL b2b_vset: valid/vl got %0b/%0d want 1/16", cfg_valid, cfg_vl); end
        insn = enc_op(F6_ADD, 1'b1, 5'd2, 5'd3, F3_IVV, 5'd1);
        @(posedge clk); #1;
        insn_valid = 1'b0;
        tests++; if ({op_valid, op_vsew, op_vl, cfg_valid} !== {1'b1, 2'd1, 6'd16, 1'b0}) begin fails++; $display("FAIL b2b_arith: valid/sew/vl/cfg got %0b/%0d/%0d/%0b want 1/1/16/0", op_valid, op_vsew, op_vl, cfg_valid); end
    endtask

    task automatic test_vl_zero();
        send(enc_vset(3'b011, 3'b101, 5'd0, 5'd1), 32'd0);
        tests++; if ({cfg_valid, cfg_vl, vtype} !== {1'b1, 32'd0, 8'h1D}) begin fails++; $display("FAIL vset_vl0: valid/vl/vtype got %0b/%0d/%h want 1/0/1d", cfg_valid, cfg_vl, vtype); end
        send(enc_op(F6_SUB, 1'b1, 5'd4, 5'd5, F3_IVV, 5'd6), 32'h0);
`ifdef RVV_VL_ZERO_SQUASH_EN
        tests++; if ({op_valid, illegal} !== 2'b00) begin fails++; $display("FAIL vl0_squash: valid/illegal got %b want 00", {op_valid, illegal}); end
`else
        tests++; if ({op_valid, illegal, op_vl, op_vsew} !== {2'b10, 6'd0, 2'd3}) begin fails++; $display("FAIL vl0_emit: valid/ill/vl/sew got %0b/%0b/%0d/%0d want 1/0/0/3", op_valid, illegal, op_vl, op_vsew); end
`endif
    endtask

    task automatic test_async_reset();
        send(enc_vset(3'b010, 3'b000, 5'd1, 5'd1), 32'd4);
        op_ready = 1'b0;
        send(enc_op(F6_ADD, 1'b1, 5'd1, 5'd2, F3_IVV, 5'd3), 32'h0);
        tests++; if (op_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_hold: got %0b want 1", op_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({op_valid, vtype, op_vd, op_vl} !== {1'b0, 8'h80, 5'd0, 6'd0}) begin fails++; $display("FAIL async_reset: valid/vtype/vd/vl got %0b/%h/%0d/%0d want 0/80/0/0", op_valid, vtype, op_vd, op_vl); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        op_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_vill_illegal();
        test_vsetvli();
        test_scalar_operand();
        test_illegal();
        test_merge();
        test_backpressure();
        test_back_to_back();
        test_vl_zero();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
